// File: rtl/vga_scan_fetch.sv
// Raster timing generator and pixel fetcher: scans the VGA frame, addresses the
// 3-bit video RAM, and presents registered RGB with aligned active-low syncs.
module vga_scan_fetch #(
    parameter int CLK_DIV    = 2,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iEnable,
    output logic [ADDR_WIDTH-1:0] oReadAddress,
    input  logic [2:0]            iPixel,
    output logic                  VGA_HSYNC,
    output logic                  VGA_VSYNC,
    output logic                  VGA_RED,
    output logic                  VGA_GREEN,
    output logic                  VGA_BLUE,
    output logic                  oFrameStart
);
    localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1;
    localparam int HW = $clog2(HT + 1);
    localparam int VW = $clog2(VT + 1);
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(HT);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(VT);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DW-1:0] div;
    logic [HW-1:0] h;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v;
    logic [VW-1:0] v_next;
    logic          tick;
    logic          h_wrap;
    logic          v_wrap;
    logic          next_origin;
    logic          next_vis;
    logic          cur_vis;
    logic          hs_active;
    logic          vs_active;
    logic          cap_pend;
    logic [2:0]    cap;
    logic [2:0]    rgb_q;

    assign {VGA_RED, VGA_GREEN, VGA_BLUE} = rgb_q;

    always_comb begin
        tick        = iEnable && (div == DIV_LAST);
        h_wrap      = (h == H_LAST);
        v_wrap      = (v == V_LAST);
        h_next      = h_wrap ? '0 : h + HW'(1);
        v_next      = v;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v + VW'(1);
        end
        next_origin = h_wrap && v_wrap;
        next_vis    = (h_next < H_VIS) && (v_next < V_VIS);
        cur_vis     = (h < H_VIS) && (v < V_VIS);
        hs_active   = (h >= HS_START) && (h < HS_END);
        vs_active   = (v >= VS_START) && (v < VS_END);
    end

    // cap_pend resets high so the very first pixel after reset is captured
    // from address 0 before the first tick edge consumes it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div          <= '0;
            h            <= '0;
            v            <= '0;
            oReadAddress <= '0;
            VGA_HSYNC    <= 1'b1;
            VGA_VSYNC    <= 1'b1;
            rgb_q        <= 3'b000;
            oFrameStart  <= 1'b0;
            cap          <= 3'b000;
            cap_pend     <= 1'b1;
        end else if (iEnable) begin
            div         <= tick ? '0 : div + DW'(1);
            cap_pend    <= tick;
            oFrameStart <= tick && next_origin;
            if (cap_pend) begin
                cap <= iPixel;
            end
            if (tick) begin
                h <= h_next;
                v <= v_next;
                if (next_origin) begin
                    oReadAddress <= '0;
                end else if (next_vis) begin
                    oReadAddress <= oReadAddress + ADDR_WIDTH'(1);
                end
                // Output stage shows the pixel that is being left on this edge.
                rgb_q     <= cur_vis ? cap : 3'b000;
                VGA_HSYNC <= ~hs_active;
                VGA_VSYNC <= ~vs_active;
            end
        end
    end
endmodule

// File: tb/tb_vga_scan_fetch.sv
// Directed bench for vga_scan_fetch on a 7x6 raster (4x3 visible) so whole
// frames fit in a few hundred clocks; RAM returns the low address bits.
module tb_vga_scan_fetch;
    localparam int AW        = 19;
    localparam int NH        = 7;
    localparam int NP        = 42;
    localparam int FRAME_CLK = 84;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [AW-1:0] addr;
    logic [2:0]    pix;
    logic          hs, vs, r, g, b, fs;

    int   n_checks = 0;
    int   n_fail   = 0;

    int   e_div, e_k, e_out_p;
    logic e_out_valid, e_fs;

    always #5 clk = ~clk;

    assign pix = addr[2:0];

    vga_scan_fetch #(
        .CLK_DIV(2), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .ADDR_WIDTH(AW)
    ) dut (
        .Clock(clk), .Reset(rst), .iEnable(en), .oReadAddress(addr), .iPixel(pix),
        .VGA_HSYNC(hs), .VGA_VSYNC(vs), .VGA_RED(r), .VGA_GREEN(g), .VGA_BLUE(b),
        .oFrameStart(fs)
    );

    // Address of raster position p: row-major in the visible area, held through blanking.
    function automatic int addr_of(input int p);
        int h, v;
        h = p % NH;
        v = p / NH;
        if (v >= 3) return 11;
        if (h >= 4) return v * 4 + 3;
        return v * 4 + h;
    endfunction

    function automatic logic [2:0] rgb_of(input int p);
        int h, v, a;
        h = p % NH;
        v = p / NH;
        a = v * 4 + h;
        if (h < 4 && v < 3) return a[2:0];
        return 3'b000;
    endfunction

    function automatic logic [AW+5:0] exp_vec();
        logic [AW-1:0] a;
        logic [2:0]    c;
        logic          h_s, v_s;
        a   = AW'(addr_of(e_k % NP));
        c   = 3'b000;
        h_s = 1'b1;
        v_s = 1'b1;
        if (e_out_valid) begin
            c   = rgb_of(e_out_p);
            h_s = ((e_out_p % NH) != 5);
            v_s = ((e_out_p / NH) != 4);
        end
        return {a, c, h_s, v_s, e_fs};
    endfunction

    task automatic model_reset();
        e_div       = 0;
        e_k         = 0;
        e_out_p     = 0;
        e_out_valid = 1'b0;
        e_fs        = 1'b0;
    endtask

    // One clock: drive enable, advance the expected raster, sample on the falling edge.
    task automatic clk_step(input logic en_i);
        en = en_i;
        @(posedge clk);
        if (en_i) begin
            if (e_div == 1) begin
                e_out_p     = e_k % NP;
                e_out_valid = 1'b1;
                e_k++;
                e_fs        = ((e_k % NP) == 0);
                e_div       = 0;
            end else begin
                e_div++;
                e_fs = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        n_checks++; if (addr !== '0)     begin n_fail++; $display("FAIL rst_addr got %0d want 0", addr); end
        n_checks++; if (hs !== 1'b1)     begin n_fail++; $display("FAIL rst_hsync got %b want 1", hs); end
        n_checks++; if (vs !== 1'b1)     begin n_fail++; $display("FAIL rst_vsync got %b want 1", vs); end
        n_checks++; if ({r, g, b} !== 3'b000) begin n_fail++; $display("FAIL rst_rgb got %b want 000", {r, g, b}); end
        n_checks++; if (fs !== 1'b0)     begin n_fail++; $display("FAIL rst_fs got %b want 0", fs); end
    endtask

    task automatic test_scan();
        logic [AW+5:0] want;
        logic [AW-1:0] max_addr;
        max_addr = '0;
        rst = 1'b0;
        for (int c = 0; c < 2 * FRAME_CLK + 4; c++) begin
            clk_step(1'b1);
            want = exp_vec();
            n_checks++;
            if ({addr, r, g, b, hs, vs, fs} !== want) begin
                n_fail++;
                $display("FAIL scan_vec clk %0d got %h want %h", c, {addr, r, g, b, hs, vs, fs}, want);
            end
            if (addr > max_addr) max_addr = addr;
        end
        n_checks++;
        if (max_addr !== AW'(11)) begin n_fail++; $display("FAIL scan_max_addr got %0d want 11", max_addr); end
    endtask

    task automatic test_pixel_latency();
        bit found;
        found = 0;
        for (int i = 0; i < 200 && addr === AW'(4); i++) clk_step(1'b1);
        for (int i = 0; i < 200 && !found; i++) begin
            clk_step(1'b1);
            if (addr === AW'(4)) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL lat_find got timeout want addr 4"); end
        clk_step(1'b1);
        n_checks++; if ({r, g, b} !== 3'b000) begin n_fail++; $display("FAIL lat_pre_rgb got %b want 000", {r, g, b}); end
        clk_step(1'b1);
        n_checks++; if ({r, g, b} !== 3'b100) begin n_fail++; $display("FAIL lat_rgb got %b want 100", {r, g, b}); end
        n_checks++; if ({hs, vs} !== 2'b11) begin n_fail++; $display("FAIL lat_sync got %b want 11", {hs, vs}); end
        n_checks++; if (addr !== AW'(5)) begin n_fail++; $display("FAIL lat_next_addr got %0d want 5", addr); end
    endtask

    task automatic test_frame_timing();
        int   n;
        bit   ok;
        logic prev;
        // frame start period
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin clk_step(1'b1); if (fs === 1'b1) ok = 1; end
        n = 0;
        for (int i = 0; i < 200 && ok; i++) begin clk_step(1'b1); n++; if (fs === 1'b1) break; end
        n_checks++;
        if (!ok || n != FRAME_CLK) begin n_fail++; $display("FAIL fs_period got %0d want %0d", n, FRAME_CLK); end
        // vsync falling-edge period
        ok = 0; prev = vs;
        for (int i = 0; i < 200 && !ok; i++) begin clk_step(1'b1); if (prev === 1'b1 && vs === 1'b0) ok = 1; prev = vs; end
        n = 0;
        for (int i = 0; i < 200 && ok; i++) begin
            clk_step(1'b1); n++;
            if (prev === 1'b1 && vs === 1'b0) break;
            prev = vs;
        end
        n_checks++;
        if (!ok || n != FRAME_CLK) begin n_fail++; $display("FAIL vs_period got %0d want %0d", n, FRAME_CLK); end
        // vsync low width
        n = 1;
        for (int i = 0; i < 200 && ok && vs === 1'b0; i++) begin clk_step(1'b1); if (vs === 1'b0) n++; end
        n_checks++;
        if (!ok || n != 14) begin n_fail++; $display("FAIL vs_width got %0d want 14", n); end
        // hsync low width
        ok = 0; prev = hs;
        for (int i = 0; i < 200 && !ok; i++) begin clk_step(1'b1); if (prev === 1'b1 && hs === 1'b0) ok = 1; prev = hs; end
        n = 1;
        for (int i = 0; i < 200 && ok && hs === 1'b0; i++) begin clk_step(1'b1); if (hs === 1'b0) n++; end
        n_checks++;
        if (!ok || n != 2) begin n_fail++; $display("FAIL hs_width got %0d want 2", n); end
    endtask

    task automatic test_enable_gap();
        logic [AW+5:0] held;
        logic [AW+5:0] want;
        bit            ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            clk_step(1'b1);
            if (e_div == 0 && e_out_valid && (e_k % NP) == 9) ok = 1;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL gap_find got timeout want position 9"); end
        held = exp_vec();
        for (int i = 0; i < 7; i++) begin
            clk_step(1'b0);
            n_checks++;
            if ({addr, r, g, b, hs, vs, fs} !== held) begin
                n_fail++;
                $display("FAIL gap_hold clk %0d got %h want %h", i, {addr, r, g, b, hs, vs, fs}, held);
            end
        end
        clk_step(1'b1);
        clk_step(1'b1);
        n_checks++;
        if (addr !== AW'(7)) begin n_fail++; $display("FAIL gap_resume_addr got %0d want 7", addr); end
        for (int c = 0; c < 12; c++) begin
            clk_step(1'b1);
            want = exp_vec();
            n_checks++;
            if ({addr, r, g, b, hs, vs, fs} !== want) begin
                n_fail++;
                $display("FAIL gap_after clk %0d got %h want %h", c, {addr, r, g, b, hs, vs, fs}, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [AW+5:0] want;
        bit            ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            clk_step(1'b1);
            if (((e_k % NP) / NH) == 2 && (e_k % NH) == 1 && e_div == 1) ok = 1;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL mid_find got timeout want row 2"); end
        rst = 1'b1;
        #1;
        n_checks++; if (addr !== '0) begin n_fail++; $display("FAIL mid_rst_addr got %0d want 0", addr); end
        n_checks++; if ({hs, vs} !== 2'b11) begin n_fail++; $display("FAIL mid_rst_sync got %b want 11", {hs, vs}); end
        n_checks++; if ({r, g, b} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_rgb got %b want 000", {r, g, b}); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < FRAME_CLK + 10; c++) begin
            clk_step(1'b1);
            want = exp_vec();
            n_checks++;
            if ({addr, r, g, b, hs, vs, fs} !== want) begin
                n_fail++;
                $display("FAIL mid_after clk %0d got %h want %h", c, {addr, r, g, b, hs, vs, fs}, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_pixel_latency();
        test_frame_timing();
        test_enable_gap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
